// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state type, default width and counter sizing for the serial subtractor
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEFAULT_WIDTH = 4;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/serial_sub_bit.sv
// serial_sub_bit: one-bit full subtractor with a borrow flop cleared synchronously
module serial_sub_bit (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic d
);
    logic bin;
    assign d = a ^ b ^ bin;
    always_ff @(posedge clk) begin
        if (rst || clr) bin <= 1'b0;
        else if (en) bin <= (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/serial_sub_signed_unsigned.sv
// serial_sub_signed_unsigned: bit-serial a-b, unsigned and signed WIDTH+1-bit results, borrow/overflow
// ACTIVE_LOW_IO_EN inverts start/in_a/in_b and every output at the pins
module serial_sub_signed_unsigned import serial_sub_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   out_diff_unsigned,
    output logic [WIDTH:0]   out_diff_signed,
    output logic             out_borrow,
    output logic             out_overflow
);
    localparam int CW = cnt_width(WIDTH);
`ifdef ACTIVE_LOW_IO_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic a_msb, b_msb;
    logic [WIDTH:0] u_sr, s_sr, u_q, s_q;
    logic go, accept, run, last;
    logic ua, ub, sa, sb, ud, sd;
    assign go = start ^ INV;
    assign run = state == RUN;
    assign accept = go && !run;
    assign last = run && cnt == CW'(WIDTH);
    assign ua = last ? 1'b0 : a_sr[0];
    assign ub = last ? 1'b0 : b_sr[0];
    assign sa = last ? a_msb : a_sr[0];
    assign sb = last ? b_msb : b_sr[0];
    serial_sub_bit u_bit (.clk(clk), .rst(rst), .clr(accept), .en(run), .a(ua), .b(ub), .d(ud));
    serial_sub_bit s_bit (.clk(clk), .rst(rst), .clr(accept), .en(run), .a(sa), .b(sb), .d(sd));
    always_comb begin
        state_nx = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            u_sr  <= '0;
            s_sr  <= '0;
            u_q   <= '0;
            s_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr  <= in_a ^ {WIDTH{INV}};
                b_sr  <= in_b ^ {WIDTH{INV}};
                a_msb <= in_a[WIDTH-1] ^ INV;
                b_msb <= in_b[WIDTH-1] ^ INV;
                cnt   <= '0;
                u_sr  <= '0;
                s_sr  <= '0;
            end else if (run) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                cnt  <= cnt + 1'b1;
                u_sr <= {ud, u_sr[WIDTH:1]};
                s_sr <= {sd, s_sr[WIDTH:1]};
                if (last) begin
                    u_q <= {ud, u_sr[WIDTH:1]};
                    s_q <= {sd, s_sr[WIDTH:1]};
                end
            end
        end
    end
    assign busy = run ^ INV;
    assign done = (state == DONE) ^ INV;
    assign out_diff_unsigned = u_q ^ {(WIDTH+1){INV}};
    assign out_diff_signed = s_q ^ {(WIDTH+1){INV}};
    assign out_borrow = u_q[WIDTH] ^ INV;
    assign out_overflow = (s_q[WIDTH] ^ s_q[WIDTH-1]) ^ INV;
endmodule

// File: tb/tb_serial_sub_signed_unsigned.sv
// tb_serial_sub_signed_unsigned: scoreboard bench with directed vectors for the serial subtractor
module tb_serial_sub_signed_unsigned;
    localparam int W = 4;
`ifdef ACTIVE_LOW_IO_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    typedef struct packed {
        logic [W:0] u;
        logic [W:0] s;
        logic       br;
        logic       ov;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_c = 1'b0;
    logic [W-1:0] a_c = '0, b_c = '0;
    logic start;
    logic [W-1:0] in_a, in_b;
    logic busy, done, out_borrow, out_overflow;
    logic [W:0] out_diff_unsigned, out_diff_signed;
    logic busy_c, done_c, br_c, ov_c;
    logic [W:0] u_c, s_c;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    assign start = start_c ^ INV;
    assign in_a = a_c ^ {W{INV}};
    assign in_b = b_c ^ {W{INV}};
    assign busy_c = busy ^ INV;
    assign done_c = done ^ INV;
    assign br_c = out_borrow ^ INV;
    assign ov_c = out_overflow ^ INV;
    assign u_c = out_diff_unsigned ^ {(W+1){INV}};
    assign s_c = out_diff_signed ^ {(W+1){INV}};
    serial_sub_signed_unsigned #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b),
        .busy(busy), .done(done), .out_diff_unsigned(out_diff_unsigned),
        .out_diff_signed(out_diff_signed), .out_borrow(out_borrow), .out_overflow(out_overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && done_c) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = q.pop_front();
                chk("diff_unsigned", 32'(u_c), 32'(e.u));
                chk("diff_signed", 32'(s_c), 32'(e.s));
                chk("borrow", 32'(br_c), 32'(e.br));
                chk("overflow", 32'(ov_c), 32'(e.ov));
            end
        end
    end
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] eu, input logic [W:0] es, input logic br, input logic ov);
        int n;
        q.push_back(exp_t'{eu, es, br, ov});
        @(negedge clk);
        a_c = a;
        b_c = b;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        a_c = ~a;
        b_c = ~b;
        chk("busy_in_run", 32'(busy_c), 32'd1);
        n = 1;
        while (!done_c && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, W + 2);
    endtask
    task automatic check_zero(input string name);
        chk({name, "_busy"}, 32'(busy_c), 0);
        chk({name, "_done"}, 32'(done_c), 0);
        chk({name, "_unsigned"}, 32'(u_c), 0);
        chk({name, "_signed"}, 32'(s_c), 0);
        chk({name, "_borrow"}, 32'(br_c), 0);
        chk({name, "_overflow"}, 32'(ov_c), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        run_op(4'd3, 4'd5, 5'b11110, 5'b11110, 1'b1, 1'b0);
        run_op(4'b1000, 4'b0001, 5'b00111, 5'b10111, 1'b0, 1'b1);
        run_op(4'b0111, 4'b1111, 5'b11000, 5'b01000, 1'b1, 1'b1);
        @(negedge clk);
        a_c = 4'd3;
        b_c = 4'd5;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done_pending", q.size(), 0);
        run_op(4'd5, 4'd2, 5'b00011, 5'b00011, 1'b0, 1'b0);
        run_op(4'hf, 4'hf, 5'b00000, 5'b00000, 1'b0, 1'b0);
        run_op(4'h0, 4'hf, 5'b10001, 5'b00001, 1'b1, 1'b0);
        run_op(4'hf, 4'h0, 5'b01111, 5'b11111, 1'b0, 1'b0);
        run_op(4'h0, 4'h0, 5'b00000, 5'b00000, 1'b0, 1'b0);
        @(negedge clk);
        a_c = 4'd0;
        b_c = 4'd0;
        start_c = 1'b1;
        repeat (3) q.push_back(exp_t'{5'b0, 5'b0, 1'b0, 1'b0});
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            chk("b2b_done", 32'(done_c), 32'(n % 6 == 0));
            chk("b2b_busy", 32'(busy_c), 32'(n % 6 != 0));
        end
        start_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_done", 32'(busy_c), 0);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
